// File: rtl/decode_ctrl_pkg.sv
// Shared decode constants for the P5 D-stage: opcodes, PCSrc encodings and
// the operand-read classification used by the hazard logic.
package decode_ctrl_pkg;

  localparam logic [31:0] RESET_PC = 32'h00003000;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  localparam logic [1:0] PC_NEXT4 = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_IDX   = 2'b10;
  localparam logic [1:0] PC_REG   = 2'b11;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_BRANCH,
    CLS_JREG,
    CLS_RALU,
    CLS_IMM,
    CLS_STORE
  } instr_cls_e;

  // Loads (100xxx) read only rs with the same timing as I-type ALU ops.
  function automatic instr_cls_e classify(input logic [5:0] op, input logic [5:0] funct);
    instr_cls_e cls;
    cls = CLS_NONE;
    if (op == OP_BEQ || op == OP_BNE)
      cls = CLS_BRANCH;
    else if (op == OP_SPECIAL)
      cls = (funct == FN_JR || funct == FN_JALR) ? CLS_JREG : CLS_RALU;
    else if (op == OP_LUI)
      cls = CLS_NONE;
    else if (op[5:3] == 3'b001 || op[5:3] == 3'b100)
      cls = CLS_IMM;
    else if (op[5:3] == 3'b101)
      cls = CLS_STORE;
    return cls;
  endfunction

endpackage

// File: rtl/decode_ctrl_hazard_unit.sv
// Tuse decode of the D-stage instruction and the Tuse/Tnew stall equation
// against the E and M stage producers.
module hazard_unit
  import decode_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] E_wreg,
  input  logic [1:0] E_tnew,
  input  logic [4:0] M_wreg,
  input  logic [1:0] M_tnew,
  output logic       stall
);

  instr_cls_e cls_p0;
  logic       rs_rd_p0, rt_rd_p0;
  logic [1:0] tuse_rs_p0, tuse_rt_p0;

  // $0 is hardwired, so a producer writing it never blocks a reader.
  function automatic logic src_hit(input logic [4:0] src, input logic [1:0] tuse,
                                   input logic [4:0] e_reg, input logic [1:0] e_tnew,
                                   input logic [4:0] m_reg, input logic [1:0] m_tnew);
    return (src != 5'd0) &&
           ((src == e_reg && e_tnew > tuse) || (src == m_reg && m_tnew > tuse));
  endfunction

  always_comb begin
    cls_p0     = classify(op, funct);
    rs_rd_p0   = 1'b0;
    rt_rd_p0   = 1'b0;
    tuse_rs_p0 = 2'd0;
    tuse_rt_p0 = 2'd0;
    case (cls_p0)
      CLS_BRANCH: begin rs_rd_p0 = 1'b1; rt_rd_p0 = 1'b1; end
      CLS_JREG:   rs_rd_p0 = 1'b1;
      CLS_RALU:   begin
        rs_rd_p0 = 1'b1; rt_rd_p0 = 1'b1; tuse_rs_p0 = 2'd1; tuse_rt_p0 = 2'd1;
      end
      CLS_IMM:    begin rs_rd_p0 = 1'b1; tuse_rs_p0 = 2'd1; end
      CLS_STORE:  begin
        rs_rd_p0 = 1'b1; rt_rd_p0 = 1'b1; tuse_rs_p0 = 2'd1; tuse_rt_p0 = 2'd2;
      end
      default: ;
    endcase
  end

  assign stall = (rs_rd_p0 && src_hit(rs, tuse_rs_p0, E_wreg, E_tnew, M_wreg, M_tnew)) ||
                 (rt_rd_p0 && src_hit(rt, tuse_rt_p0, E_wreg, E_tnew, M_wreg, M_tnew));

endmodule

// File: rtl/decode_ctrl.sv
// P5 D-stage front end: IF/ID register, branch/jump decode driving fetch's
// next-PC select, and hazard stall with E-stage bubble insertion.
module decode_ctrl #(
  parameter logic [31:0] RESET_PC = decode_ctrl_pkg::RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr_F,
  input  logic [31:0]      PC_4_F,
  input  logic [31:0]      RD1,
  input  logic [31:0]      RD2,
  input  logic [4:0]       E_wreg,
  input  logic [1:0]       E_tnew,
  input  logic [4:0]       M_wreg,
  input  logic [1:0]       M_tnew,
  output logic             EN,
  output logic [1:0]       PCSrc,
  output logic [31:0]      ext_imm,
  output logic [31:0]      ext_index,
  output logic [31:0]      GPR_rs,
  output logic [31:0]      Instr_D,
  output logic [31:0]      PC_4_D,
  output logic             bubble_E,
  output logic [CNT_W-1:0] stall_cnt
);
  import decode_ctrl_pkg::*;

  logic [5:0]        op_p0, funct_p0;
  logic              stall_p0;
  logic [1:0]        pcsrc_p0;
  logic signed [31:0] imm_sext_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign op_p0    = Instr_D[31:26];
  assign funct_p0 = Instr_D[5:0];

  hazard_unit u_hazard (
    .op     (op_p0),
    .funct  (funct_p0),
    .rs     (Instr_D[25:21]),
    .rt     (Instr_D[20:16]),
    .E_wreg (E_wreg),
    .E_tnew (E_tnew),
    .M_wreg (M_wreg),
    .M_tnew (M_tnew),
    .stall  (stall_p0)
  );

  always_comb begin
    pcsrc_p0 = PC_NEXT4;
    case (op_p0)
      OP_BEQ:     if (RD1 == RD2) pcsrc_p0 = PC_BR;
      OP_BNE:     if (RD1 != RD2) pcsrc_p0 = PC_BR;
      OP_J,
      OP_JAL:     pcsrc_p0 = PC_IDX;
      OP_SPECIAL: if (funct_p0 == FN_JR || funct_p0 == FN_JALR) pcsrc_p0 = PC_REG;
      default: ;
    endcase
  end

  assign imm_sext_p0 = 32'(signed'(Instr_D[15:0]));

  // A stalled branch must not redirect fetch: it is re-evaluated once operands are ready.
  assign PCSrc     = stall_p0 ? PC_NEXT4 : pcsrc_p0;
  assign EN        = ~stall_p0;
  assign bubble_E  = stall_p0;
  assign ext_imm   = imm_sext_p0;
  assign ext_index = {PC_4_D[31:28], Instr_D[25:0], 2'b00};
  assign GPR_rs    = RD1;

  // IF/ID register boundary (F -> D)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Instr_D <= 32'd0;
      PC_4_D  <= RESET_PC + 32'd4;
    end else if (!stall_p0) begin
      Instr_D <= Instr_F;
      PC_4_D  <= PC_4_F;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall_p0)
      stall_cnt <= sat_inc(stall_cnt);
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl: reset, branch/jump select, hazard stalls,
// delay-slot latching, counter saturation and asynchronous reset mid-stall.
module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr_F, PC_4_F, RD1, RD2;
  logic [4:0]  E_wreg, M_wreg;
  logic [1:0]  E_tnew, M_tnew;
  logic        EN, bubble_E;
  logic [1:0]  PCSrc;
  logic [31:0] ext_imm, ext_index, GPR_rs, Instr_D, PC_4_D;
  logic [31:0] stall_cnt;

  logic        s_EN, s_bubble_E;
  logic [1:0]  s_PCSrc;
  logic [31:0] s_ext_imm, s_ext_index, s_GPR_rs, s_Instr_D, s_PC_4_D;
  logic [1:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  localparam logic [31:0] I_BEQ = 32'h10220003;  // beq $1,$2,+3
  localparam logic [31:0] I_BNE = 32'h1422FFFE;  // bne $1,$2,-2
  localparam logic [31:0] I_J   = 32'h08000C04;  // j 0x0000C04
  localparam logic [31:0] I_JR  = 32'h03E00008;  // jr $31
  localparam logic [31:0] I_ADD = 32'h00851820;  // add $3,$4,$5
  localparam logic [31:0] I_AD0 = 32'h00051820;  // add $3,$0,$5
  localparam logic [31:0] I_SW  = 32'hAC850000;  // sw $5,0($4)
  localparam logic [31:0] I_LUI = 32'h3C050000;  // lui $5,0
  localparam logic [31:0] I_ORI = 32'h34850001;  // ori $5,$4,1

  always #5 clk = ~clk;

  decode_ctrl dut (
    .clk(clk), .reset(reset), .Instr_F(Instr_F), .PC_4_F(PC_4_F), .RD1(RD1), .RD2(RD2),
    .E_wreg(E_wreg), .E_tnew(E_tnew), .M_wreg(M_wreg), .M_tnew(M_tnew),
    .EN(EN), .PCSrc(PCSrc), .ext_imm(ext_imm), .ext_index(ext_index), .GPR_rs(GPR_rs),
    .Instr_D(Instr_D), .PC_4_D(PC_4_D), .bubble_E(bubble_E), .stall_cnt(stall_cnt)
  );

  decode_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .Instr_F(Instr_F), .PC_4_F(PC_4_F), .RD1(RD1), .RD2(RD2),
    .E_wreg(E_wreg), .E_tnew(E_tnew), .M_wreg(M_wreg), .M_tnew(M_tnew),
    .EN(s_EN), .PCSrc(s_PCSrc), .ext_imm(s_ext_imm), .ext_index(s_ext_index),
    .GPR_rs(s_GPR_rs), .Instr_D(s_Instr_D), .PC_4_D(s_PC_4_D), .bubble_E(s_bubble_E),
    .stall_cnt(s_stall_cnt)
  );

  task automatic clear_hazards();
    E_wreg = 5'd0; E_tnew = 2'd0; M_wreg = 5'd0; M_tnew = 2'd0;
  endtask

  task automatic load(input logic [31:0] instr, input logic [31:0] pc4);
    clear_hazards();
    Instr_F = instr; PC_4_F = pc4;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; Instr_F = I_BEQ; PC_4_F = 32'h0; RD1 = 32'h0; RD2 = 32'h0;
    clear_hazards();
    repeat (2) @(posedge clk); #1;
    checks++; if (Instr_D !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want %h", Instr_D, 32'h0); end
    checks++; if (PC_4_D !== 32'h00003004) begin errors++; $display("FAIL reset_pc4: got %h want %h", PC_4_D, 32'h00003004); end
    checks++; if (EN !== 1'b1 || bubble_E !== 1'b0 || PCSrc !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got EN=%b bub=%b pcsrc=%b want 1 0 00", EN, bubble_E, PCSrc); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_beq();
    load(I_BEQ, 32'h00003008);
    RD1 = 32'd5; RD2 = 32'd5; #1;
    checks++; if (PCSrc !== 2'b01) begin errors++; $display("FAIL beq_taken: got %b want 01", PCSrc); end
    checks++; if (ext_imm !== 32'h00000003) begin errors++; $display("FAIL beq_imm: got %h want 00000003", ext_imm); end
    checks++; if (EN !== 1'b1) begin errors++; $display("FAIL beq_en: got %b want 1", EN); end
    RD2 = 32'd6; #1;
    checks++; if (PCSrc !== 2'b00) begin errors++; $display("FAIL beq_not_taken: got %b want 00", PCSrc); end
    RD2 = 32'd5; Instr_F = I_ADD; PC_4_F = 32'h0000300C;
    @(posedge clk); #1;
    checks++; if (Instr_D !== I_ADD || PC_4_D !== 32'h0000300C) begin errors++; $display("FAIL beq_delay_slot: got %h/%h want %h/%h", Instr_D, PC_4_D, I_ADD, 32'h0000300C); end
  endtask

  task automatic test_bne();
    load(I_BNE, 32'h00003010);
    RD1 = 32'd1; RD2 = 32'd2; #1;
    checks++; if (PCSrc !== 2'b01) begin errors++; $display("FAIL bne_taken: got %b want 01", PCSrc); end
    checks++; if (ext_imm !== 32'hFFFFFFFE) begin errors++; $display("FAIL bne_imm: got %h want FFFFFFFE", ext_imm); end
    RD2 = 32'd1; #1;
    checks++; if (PCSrc !== 2'b00) begin errors++; $display("FAIL bne_not_taken: got %b want 00", PCSrc); end
  endtask

  task automatic test_j();
    load(I_J, 32'h00003008);
    checks++; if (PCSrc !== 2'b10) begin errors++; $display("FAIL j_pcsrc: got %b want 10", PCSrc); end
    checks++; if (ext_index !== 32'h00003010) begin errors++; $display("FAIL j_index: got %h want 00003010", ext_index); end
  endtask

  task automatic test_jr_stall();
    load(I_JR, 32'h0000300C);
    E_wreg = 5'd31; E_tnew = 2'd1; RD1 = 32'h00004000; Instr_F = I_SW; PC_4_F = 32'h00003010; #1;
    checks++; if (EN !== 1'b0 || bubble_E !== 1'b1 || PCSrc !== 2'b00) begin errors++; $display("FAIL jr_stall: got EN=%b bub=%b pcsrc=%b want 0 1 00", EN, bubble_E, PCSrc); end
    checks++; if (stall_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL jr_cnt_before: got %0d want %0d", stall_cnt, exp_cnt); end
    @(posedge clk); #1; exp_cnt++;
    checks++; if (Instr_D !== I_JR || PC_4_D !== 32'h0000300C) begin errors++; $display("FAIL jr_hold: got %h/%h want %h/0000300C", Instr_D, PC_4_D, I_JR); end
    checks++; if (stall_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL jr_cnt_after: got %0d want %0d", stall_cnt, exp_cnt); end
    E_tnew = 2'd0; #1;
    checks++; if (EN !== 1'b1 || bubble_E !== 1'b0 || PCSrc !== 2'b11) begin errors++; $display("FAIL jr_release: got EN=%b bub=%b pcsrc=%b want 1 0 11", EN, bubble_E, PCSrc); end
    checks++; if (GPR_rs !== 32'h00004000) begin errors++; $display("FAIL jr_gpr_rs: got %h want 00004000", GPR_rs); end
    M_wreg = 5'd31; M_tnew = 2'd1; #1;
    checks++; if (EN !== 1'b0) begin errors++; $display("FAIL jr_m_stall: got EN=%b want 0", EN); end
    M_tnew = 2'd0;
    @(posedge clk); #1;
    checks++; if (Instr_D !== I_SW || stall_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL jr_advance: got %h cnt %0d want %h cnt %0d", Instr_D, stall_cnt, I_SW, exp_cnt); end
  endtask

  task automatic test_add_hazard();
    load(I_ADD, 32'h00003014);
    M_wreg = 5'd5; M_tnew = 2'd1; #1;
    checks++; if (EN !== 1'b1) begin errors++; $display("FAIL add_m_tuse1: got EN=%b want 1", EN); end
    E_wreg = 5'd4; E_tnew = 2'd2; #1;
    checks++; if (EN !== 1'b0 || bubble_E !== 1'b1) begin errors++; $display("FAIL add_e_stall: got EN=%b bub=%b want 0 1", EN, bubble_E); end
    E_wreg = 5'd0; #1;
    checks++; if (EN !== 1'b1) begin errors++; $display("FAIL add_e_zero: got EN=%b want 1", EN); end
    load(I_AD0, 32'h00003018);
    E_wreg = 5'd0; E_tnew = 2'd3; M_wreg = 5'd0; M_tnew = 2'd3; #1;
    checks++; if (EN !== 1'b1) begin errors++; $display("FAIL add_rs_zero: got EN=%b want 1", EN); end
  endtask

  task automatic test_store();
    load(I_SW, 32'h0000301C);
    E_wreg = 5'd5; E_tnew = 2'd2; #1;
    checks++; if (EN !== 1'b1) begin errors++; $display("FAIL sw_rt_tnew2: got EN=%b want 1", EN); end
    E_tnew = 2'd3; #1;
    checks++; if (EN !== 1'b0) begin errors++; $display("FAIL sw_rt_tnew3: got EN=%b want 0", EN); end
    E_wreg = 5'd4; E_tnew = 2'd2; #1;
    checks++; if (EN !== 1'b0) begin errors++; $display("FAIL sw_rs_tnew2: got EN=%b want 0", EN); end
  endtask

  task automatic test_itype();
    load(I_LUI, 32'h00003020);
    E_wreg = 5'd5; E_tnew = 2'd3; #1;
    checks++; if (EN !== 1'b1 || PCSrc !== 2'b00) begin errors++; $display("FAIL lui_no_read: got EN=%b pcsrc=%b want 1 00", EN, PCSrc); end
    load(I_ORI, 32'h00003024);
    E_wreg = 5'd5; E_tnew = 2'd3; #1;
    checks++; if (EN !== 1'b1) begin errors++; $display("FAIL ori_rt_dest: got EN=%b want 1", EN); end
    M_wreg = 5'd4; M_tnew = 2'd2; #1;
    checks++; if (EN !== 1'b0) begin errors++; $display("FAIL ori_rs_m: got EN=%b want 0", EN); end
  endtask

  task automatic test_saturation();
    int sat_exp;
    load(I_BEQ, 32'h00003028);
    E_wreg = 5'd2; E_tnew = 2'd1;
    repeat (5) @(posedge clk);
    #1; exp_cnt += 5;
    sat_exp = (exp_cnt > 3) ? 3 : exp_cnt;
    checks++; if (stall_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL cnt_main: got %0d want %0d", stall_cnt, exp_cnt); end
    checks++; if (s_stall_cnt !== 2'(sat_exp)) begin errors++; $display("FAIL cnt_saturate: got %0d want %0d", s_stall_cnt, sat_exp); end
    checks++; if (Instr_D !== I_BEQ || s_EN !== 1'b0) begin errors++; $display("FAIL sat_hold: got %h en %b want %h en 0", Instr_D, s_EN, I_BEQ); end
  endtask

  task automatic test_reset_mid_stall();
    #2; reset = 1'b1; #1;
    checks++; if (Instr_D !== 32'h0 || PC_4_D !== 32'h00003004) begin errors++; $display("FAIL async_reset_regs: got %h/%h want 00000000/00003004", Instr_D, PC_4_D); end
    checks++; if (EN !== 1'b1 || PCSrc !== 2'b00 || bubble_E !== 1'b0) begin errors++; $display("FAIL async_reset_ctrl: got EN=%b pcsrc=%b bub=%b want 1 00 0", EN, PCSrc, bubble_E); end
    checks++; if (stall_cnt !== 32'd0 || s_stall_cnt !== 2'd0) begin errors++; $display("FAIL async_reset_cnt: got %0d/%0d want 0/0", stall_cnt, s_stall_cnt); end
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_beq();
    test_bne();
    test_j();
    test_jr_stall();
    test_add_hazard();
    test_store();
    test_itype();
    test_saturation();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_ctrl.md
Name: decode_ctrl

Overview:
- D-stage front end of the P5 five-stage MIPS pipeline; it sits on the consuming side of the fetch stage's next-PC interface.
- Latches Instr/PC_4 from fetch into the IF/ID register and decodes branch/jump instructions.
- Drives the fetch-side PCSrc, ext_imm, ext_index, GPR_rs and EN inputs. Detects Tuse/Tnew data hazards, stalls fetch and inserts E-stage bubbles.

Parameters:
- RESET_PC, 32'h00003000, reset value used to form PC_4_D (RESET_PC+4).
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- Instr_F  in  32  instruction from fetch
- PC_4_F  in  32  PC+4 from fetch
- RD1  in  32  forwarded GPR[rs] value
- RD2  in  32  forwarded GPR[rt] value
- E_wreg  in  5  E-stage destination register (0 = none)
- E_tnew  in  2  E-stage cycles until result ready
- M_wreg  in  5  M-stage destination register
- M_tnew  in  2  M-stage cycles until result ready
- EN  out  1  fetch PC enable (0 = hold PC)
- PCSrc  out  2  00 PC+4, 01 branch offset, 10 index, 11 register
- ext_imm  out  32  sign-extended Instr_D[15:0]
- ext_index  out  32  {PC_4_D[31:28], Instr_D[25:0], 2'b00}
- GPR_rs  out  32  RD1 passthrough (jr/jalr target)
- Instr_D  out  32  IF/ID instruction register
- PC_4_D  out  32  IF/ID PC+4 register
- bubble_E  out  1  clear D/E register this cycle
- stall_cnt  out  CNT_W  count of stall cycles, saturating

Behaviour:
- Reset (async, any cycle, including mid-stall):
  - Instr_D=0 (nop), PC_4_D=RESET_PC+4, stall_cnt=0.
  - Combinational outputs follow: EN=1, PCSrc=00, bubble_E=0.
- Decode of Instr_D (op = [31:26], funct = [5:0]):
  - beq: op 000100. bne: op 000101. j: op 000010. jal: op 000011.
  - jr: op 0, funct 001000. jalr: op 0, funct 001001.
  - Everything else is non-control.
- Tuse (cycles until the D-stage instruction needs the operand):
  - beq/bne: rs and rt, Tuse=0.
  - jr/jalr: rs, Tuse=0.
  - R-type ALU: rs and rt, Tuse=1.
  - I-type ALU and load: rs, Tuse=1.
  - Store: rs Tuse=1, rt Tuse=2.
  - j/jal/lui/nop: no reads.
- stall = for each read source s (s != 0): (s==E_wreg && E_tnew>Tuse_s) || (s==M_wreg && M_tnew>Tuse_s).
- When stall=1:
  - EN=0, bubble_E=1, PCSrc=00.
  - IF/ID holds its value.
  - stall_cnt increments, saturating at all-ones.
- When stall=0:
  - EN=1, bubble_E=0.
  - IF/ID loads Instr_F/PC_4_F on the clock edge.
- PCSrc when not stalled:
  - beq: 01 if RD1==RD2, else 00.
  - bne: 01 if RD1!=RD2, else 00.
  - j/jal: 10.
  - jr/jalr: 11.
  - Otherwise 00.
- Branch delay slot is architectural:
  - The instruction after a taken branch still enters IF/ID and is never flushed.
  - Fetch computes the target as (fetch PC)+(ext_imm<<2), where fetch PC = branch PC+4.
- Register 0 never causes a stall, even if E_wreg or M_wreg is 0.
- Simultaneous E and M matches: stall if either condition holds.
- ext_imm and ext_index are computed regardless of instruction type.
- Arithmetic: 32-bit, wrap-around, no overflow traps.

Decomposition:
- Shared package holds:
  - opcode/funct constants (OP_BEQ, OP_BNE, OP_J, OP_JAL, FN_JR, FN_JALR);
  - PCSrc encodings (PC_NEXT4, PC_BR, PC_IDX, PC_REG);
  - RESET_PC.
- One natural sub-module, hazard_unit: combinational Tuse decode plus the stall equation.
- IF/ID register, branch compare and stall counter stay in decode_ctrl.

Test Plan:
- Reset asserted mid-stall with Instr_D=beq → outputs immediately Instr_D=0, PC_4_D=32'h00003004, EN=1, PCSrc=00, stall_cnt=0.
- beq $1,$2,+3 with RD1=RD2=5, no hazards → PCSrc=01, ext_imm=32'h00000003, EN=1. Next edge latches the delay slot from Instr_F.
- bne with imm 16'hFFFE, RD1=1, RD2=2 → PCSrc=01, ext_imm=32'hFFFFFFFE. Same instruction with RD1=RD2 → PCSrc=00.
- j with index 26'h0000C04 and PC_4_D=32'h00003008 → PCSrc=10, ext_index=32'h00003010.
- jr $31, E_wreg=31, E_tnew=1 → 1 stall cycle: EN=0, bubble_E=1, Instr_D held, stall_cnt 0→1. Then E_tnew=0 → PCSrc=11, GPR_rs=RD1.
- add $3,$4,$5 with M_wreg=5, M_tnew=1 → no stall (Tuse=1). With E_wreg=4, E_tnew=2 → stall. With E_wreg=0, E_tnew=2 → no stall.
